// File: rtl/ebu_arbiter.sv
// Two-manager AHB arbiter for the EBU: LSU has priority, a saved IFU request
// gets the next turn, and fixed-length bursts keep ownership until their last beat.
//
// state   | meaning
// IDLE    | no burst owner; selection decided per cycle from requests and ifu_pend
// LSU_OWN | LSU owns the bus until the final address phase of its burst is accepted
// IFU_OWN | IFU owns the bus until the final address phase of its burst is accepted
module ebu_arbiter #(
  parameter int BEAT_BITS = 4
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       LSUReq,
  input  logic       IFUReq,
  input  logic [1:0] HTRANS,
  input  logic [2:0] HBURST,
  input  logic       HREADY,
  output logic       LSUSelect,
  output logic       IFUSave,
  output logic       IFURestore,
  output logic       IFUDisable,
  output logic       LSUDisable
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LSU_OWN = 2'd1,
    IFU_OWN = 2'd2
  } state_t;

  state_t               state_q;
  logic                 ifu_pend_q;
  logic [BEAT_BITS-1:0] beat_cnt_q;
  logic [BEAT_BITS-1:0] last_beat;
  logic                 acc;
  logic                 final_beat;
  logic                 lsu_sel;

  assign acc = HREADY & (HTRANS != 2'b00);

  // Index of the last beat; INCR and wrapping bursts are arbitrated beat by beat.
  always_comb begin
    last_beat = '0;
    case (HBURST)
      3'b011:  last_beat = BEAT_BITS'(3);
      3'b101:  last_beat = BEAT_BITS'(7);
      3'b111:  last_beat = BEAT_BITS'(15);
      default: last_beat = '0;
    endcase
  end

  assign final_beat = (beat_cnt_q == last_beat);

  always_comb begin
    lsu_sel = 1'b0;
    case (state_q)
      IDLE:    lsu_sel = ~ifu_pend_q & LSUReq;
      LSU_OWN: lsu_sel = 1'b1;
      IFU_OWN: lsu_sel = 1'b0;
      default: lsu_sel = 1'b0;
    endcase
  end

  assign LSUSelect  = lsu_sel;
  assign IFUDisable = lsu_sel;
  assign LSUDisable = ~lsu_sel;
  assign IFUSave    = IFUReq & lsu_sel & ~ifu_pend_q;
  assign IFURestore = ifu_pend_q & ~lsu_sel;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= IDLE;
      ifu_pend_q <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      if (IFUSave)
        ifu_pend_q <= 1'b1;
      else if (acc && !lsu_sel)
        ifu_pend_q <= 1'b0;

      if (acc)
        beat_cnt_q <= final_beat ? '0 : beat_cnt_q + 1'b1;

      case (state_q)
        IDLE:
          if (acc && !final_beat)
            state_q <= lsu_sel ? LSU_OWN : IFU_OWN;
        LSU_OWN, IFU_OWN:
          if (acc && final_beat)
            state_q <= IDLE;
        default:
          state_q <= IDLE;
      endcase
    end
  end

endmodule
